// File: rtl/stack_cpu.sv
// stack_cpu: 16-bit stack-machine core with a 16-entry operand stack and one
// shared synchronous memory port, sequenced as fetch / execute / load-writeback.
module stack_cpu (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  mem_addr,
  input  logic [15:0] rd_data,
  output logic [15:0] wr_data,
  output logic        mem_wr
);

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_EXEC  = 2'd1,
    PH_LOAD  = 2'd2
  } phase_t;

  typedef enum logic [2:0] {
    SO_NONE,
    SO_PUSH,
    SO_POP,
    SO_POP2,
    SO_REPLACE,
    SO_POP_REPLACE
  } stack_op_t;

  localparam logic [9:0] RESET_PC = 10'h200;

  phase_t      phase, phase_nxt;
  logic [9:0]  pc, pc_nxt;
  logic [15:0] insn;
  logic [15:0] alu_out;
  logic [15:0] stack [0:15];

  stack_op_t   stack_op;
  logic [15:0] stack_val;
  logic        mem_wr_req;

  // During execute the instruction is still on rd_data; later phases use insn.
  logic [15:0] cur_insn;
  logic [7:0]  opc;
  logic [7:0]  imm8;
  assign cur_insn = (phase == PH_EXEC) ? rd_data : insn;
  assign opc      = cur_insn[15:8];
  assign imm8     = cur_insn[7:0];

  logic [15:0] tos, nos;
  assign tos = stack[0];
  assign nos = stack[1];

  logic [9:0] pc_inc, br_target, ld_addr, st_addr;
  assign pc_inc    = pc + 10'd2;
  assign br_target = pc_inc + {imm8[7], imm8, 1'b0};
  // opc[0] selects the direct form of a load, opc[1] the direct form of a store.
  assign ld_addr   = opc[0] ? {2'b00, imm8} : tos[9:0];
  assign st_addr   = opc[1] ? {2'b00, imm8} : nos[9:0];

  logic        byte_mode;
  logic [7:0]  ld_byte;
  logic [15:0] ld_val;
  assign byte_mode = opc[3];
  assign ld_byte   = ld_addr[0] ? rd_data[15:8] : rd_data[7:0];
  assign ld_val    = byte_mode ? {8'h00, ld_byte} : rd_data;
  assign wr_data   = byte_mode ? {8'h00, tos[7:0]} : tos;

  logic [3:0] sh_amt;
  logic       alu_ok;
  logic       alu_unary;
  assign sh_amt = tos[3:0];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    alu_out   = '0;
    alu_ok    = 1'b1;
    alu_unary = 1'b0;
    case (imm8)
      8'h02: alu_out = nos + tos;
      8'h03: alu_out = nos - tos;
      8'h04: alu_out = nos * tos;
      8'h05: alu_out = {nos[7:0], tos[7:0]};
      8'h08: alu_out = {15'd0, $signed(nos) < $signed(tos)};
      8'h09: alu_out = {15'd0, nos == tos};
      8'h0a: alu_out = {15'd0, nos != tos};
      8'h10: alu_out = nos & tos;
      8'h11: alu_out = nos ^ tos;
      8'h12: alu_out = nos | tos;
      8'h13: begin
        alu_out   = ~tos;
        alu_unary = 1'b1;
      end
      8'h14: alu_out = nos >> sh_amt;
      8'h15: alu_out = nos << sh_amt;
      8'h16: alu_out = $signed(nos) >>> sh_amt;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    phase_nxt  = PH_FETCH;
    pc_nxt     = pc;
    stack_op   = SO_NONE;
    stack_val  = '0;
    mem_addr   = pc;
    mem_wr_req = 1'b0;
    case (phase)
      PH_FETCH: phase_nxt = PH_EXEC;
      PH_EXEC: begin
        phase_nxt = PH_FETCH;
        pc_nxt    = pc_inc;
        if (!opc[7]) begin
          stack_op  = SO_PUSH;
          stack_val = {1'b0, cur_insn[14:0]};
        end else begin
          case (opc)
            8'h81: stack_op = SO_POP;
            8'h82: begin
              stack_op  = SO_PUSH;
              stack_val = tos;
            end
            8'h90, 8'h91, 8'h98, 8'h99: begin
              mem_addr  = ld_addr;
              phase_nxt = PH_LOAD;
              pc_nxt    = pc;
            end
            8'h94, 8'h9c: begin
              mem_addr   = st_addr;
              mem_wr_req = 1'b1;
              stack_op   = SO_POP2;
            end
            8'h95, 8'h9d, 8'h96, 8'h9e: begin
              mem_addr   = st_addr;
              mem_wr_req = 1'b1;
              stack_op   = SO_POP;
            end
            8'ha0: pc_nxt = br_target;
            8'ha1: begin
              stack_op = SO_POP;
              if (tos == 16'd0) pc_nxt = br_target;
            end
            8'ha2: begin
              stack_op = SO_POP;
              if (tos != 16'd0) pc_nxt = br_target;
            end
            8'hb0: begin
              if (alu_ok) begin
                stack_op  = alu_unary ? SO_REPLACE : SO_POP_REPLACE;
                stack_val = alu_out;
              end
            end
            default: ;
          endcase
        end
      end
      PH_LOAD: begin
        mem_addr  = ld_addr;
        pc_nxt    = pc_inc;
        stack_val = ld_val;
        stack_op  = opc[0] ? SO_PUSH : SO_REPLACE;
      end
      default: phase_nxt = PH_FETCH;
    endcase
  end

  assign mem_wr = mem_wr_req & ~rst;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_FETCH;
      pc    <= RESET_PC;
      insn  <= '0;
    end else begin
      phase <= phase_nxt;
      pc    <= pc_nxt;
      if (phase == PH_EXEC) insn <= rd_data;
    end
  end

  // NOTE: the stack is a flop array, not a RAM macro, so clearing every entry
  // on reset is legal and the software relies on it reading back as zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) stack[i] <= '0;
    end else begin
      case (stack_op)
        SO_PUSH: begin
          for (int i = 15; i > 0; i--) stack[i] <= stack[i-1];
          stack[0] <= stack_val;
        end
        SO_POP: begin
          for (int i = 0; i < 15; i++) stack[i] <= stack[i+1];
          stack[15] <= '0;
        end
        SO_POP2: begin
          for (int i = 0; i < 14; i++) stack[i] <= stack[i+2];
          stack[14] <= '0;
          stack[15] <= '0;
        end
        SO_REPLACE: stack[0] <= stack_val;
        SO_POP_REPLACE: begin
          stack[0] <= stack_val;
          for (int i = 1; i < 15; i++) stack[i] <= stack[i+1];
          stack[15] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cpu.sv
// Self-checking bench for stack_cpu: table-driven programs plus hand-written
// sequences for reset, store timing, loads, branches, pc wrap and stack depth.
module tb_stack_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  mem_addr;
  logic [15:0] rd_data;
  logic [15:0] wr_data;
  logic        mem_wr;

  stack_cpu dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .rd_data  (rd_data),
    .wr_data  (wr_data),
    .mem_wr   (mem_wr)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] NOP = 16'hFF00;

  // Read-only word RAM with one cycle of read latency; writes are logged instead.
  logic [15:0] mem [0:511];
  always @(posedge clk) rd_data <= mem[mem_addr[9:1]];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  int          wr_cnt;
  int          w_cyc;
  logic [9:0]  w_addr;
  logic [15:0] w_data;

  typedef struct {
    string            name;
    logic [5:0][15:0] prog;
    int               cycles;
    logic [15:0]      top;
    logic [15:0]      s1;
    logic [9:0]       pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name,
                         input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                         input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5,
                         input int cycles, input logic [15:0] top, input logic [15:0] s1,
                         input logic [9:0] pc);
    vec_t v;
    v.name    = name;
    v.prog[0] = w0;
    v.prog[1] = w1;
    v.prog[2] = w2;
    v.prog[3] = w3;
    v.prog[4] = w4;
    v.prog[5] = w5;
    v.cycles  = cycles;
    v.top     = top;
    v.s1      = s1;
    v.pc      = pc;
    vecs.push_back(v);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = NOP;
    mem[1] = 16'h0041;
    mem[8] = 16'hAB12;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    cyc    = 0;
    wr_cnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (mem_wr === 1'b1) begin
        wr_cnt++;
        w_cyc  = cyc;
        w_addr = mem_addr;
        w_data = wr_data;
      end
    end
  endtask

  initial begin
    add_vec("add",        16'h0003, 16'h0004, 16'hB002, NOP, NOP, NOP, 6, 16'h0007, 16'h0000, 10'h206);
    add_vec("sub",        16'h0003, 16'h000A, 16'hB003, NOP, NOP, NOP, 6, 16'hFFF9, 16'h0000, 10'h206);
    add_vec("mul",        16'h0123, 16'h0010, 16'hB004, NOP, NOP, NOP, 6, 16'h1230, 16'h0000, 10'h206);
    add_vec("join",       16'h1234, 16'h0056, 16'hB005, NOP, NOP, NOP, 6, 16'h3456, 16'h0000, 10'h206);
    add_vec("lt_neg",     16'h7FFF, 16'h0001, 16'hB002, 16'h0000, 16'hB008, NOP, 10, 16'h0001, 16'h0000, 10'h20A);
    add_vec("lt_7fff",    16'h7FFF, 16'h0001, 16'h000F, 16'hB015, 16'hB008, NOP, 10, 16'h0000, 16'h0000, 10'h20A);
    add_vec("eq",         16'h0005, 16'h0005, 16'hB009, NOP, NOP, NOP, 6, 16'h0001, 16'h0000, 10'h206);
    add_vec("neq",        16'h0005, 16'h0005, 16'hB00A, NOP, NOP, NOP, 6, 16'h0000, 16'h0000, 10'h206);
    add_vec("and",        16'h00F0, 16'h003C, 16'hB010, NOP, NOP, NOP, 6, 16'h0030, 16'h0000, 10'h206);
    add_vec("xor",        16'h00F0, 16'h003C, 16'hB011, NOP, NOP, NOP, 6, 16'h00CC, 16'h0000, 10'h206);
    add_vec("or",         16'h00F0, 16'h003C, 16'hB012, NOP, NOP, NOP, 6, 16'h00FC, 16'h0000, 10'h206);
    add_vec("shr",        16'h00F0, 16'h0004, 16'hB014, NOP, NOP, NOP, 6, 16'h000F, 16'h0000, 10'h206);
    add_vec("shr_amt4",   16'h00F0, 16'h0014, 16'hB014, NOP, NOP, NOP, 6, 16'h000F, 16'h0000, 10'h206);
    add_vec("shl",        16'h00F0, 16'h0004, 16'hB015, NOP, NOP, NOP, 6, 16'h0F00, 16'h0000, 10'h206);
    add_vec("sar",        16'h7FFF, 16'h0001, 16'hB002, 16'h0001, 16'hB016, NOP, 10, 16'hC000, 16'h0000, 10'h20A);
    add_vec("not",        16'h00F0, 16'hB013, NOP, NOP, NOP, NOP, 4, 16'hFF0F, 16'h0000, 10'h204);
    add_vec("dup",        16'h0042, 16'h8200, 16'hB002, NOP, NOP, NOP, 6, 16'h0084, 16'h0000, 10'h206);
    add_vec("pop",        16'h0011, 16'h0022, 16'h8100, NOP, NOP, NOP, 6, 16'h0011, 16'h0000, 10'h206);
    add_vec("push_max",   16'h7FFF, NOP, NOP, NOP, NOP, NOP, 2, 16'h7FFF, 16'h0000, 10'h202);
    add_vec("alu_undef",  16'h0001, 16'h0002, 16'hB0FF, NOP, NOP, NOP, 6, 16'h0002, 16'h0001, 10'h206);
    add_vec("op_undef",   16'h0005, 16'hC012, NOP, NOP, NOP, NOP, 4, 16'h0005, 16'h0000, 10'h204);
    add_vec("mem_undef",  16'h0005, 16'h9212, NOP, NOP, NOP, NOP, 4, 16'h0005, 16'h0000, 10'h204);
    add_vec("jmp",        16'hA002, 16'h0001, 16'h0002, 16'h0003, NOP, NOP, 4, 16'h0003, 16'h0000, 10'h208);
    add_vec("jz_taken",   16'h0009, 16'h0000, 16'hA102, 16'h0001, 16'h0002, 16'h0003, 8, 16'h0003, 16'h0009, 10'h20C);
    add_vec("jz_not",     16'h0009, 16'h0005, 16'hA102, 16'h0001, NOP, NOP, 8, 16'h0001, 16'h0009, 10'h208);
    add_vec("jnz_not",    16'h0009, 16'h0000, 16'hA2FE, 16'h0004, NOP, NOP, 8, 16'h0004, 16'h0009, 10'h208);
    add_vec("ldd",        16'h9102, NOP, NOP, NOP, NOP, NOP, 3, 16'h0041, 16'h0000, 10'h202);
    add_vec("ld",         16'h0010, 16'h9000, NOP, NOP, NOP, NOP, 5, 16'hAB12, 16'h0000, 10'h204);
    add_vec("ld1_odd",    16'h0011, 16'h9800, NOP, NOP, NOP, NOP, 5, 16'h00AB, 16'h0000, 10'h204);
    add_vec("ldd1_even",  16'h9910, NOP, NOP, NOP, NOP, NOP, 3, 16'h0012, 16'h0000, 10'h202);
    add_vec("ldd1_odd",   16'h9911, NOP, NOP, NOP, NOP, NOP, 3, 16'h00AB, 16'h0000, 10'h202);
    add_vec("st",         16'h0009, 16'h0020, 16'h0055, 16'h9400, NOP, NOP, 8, 16'h0009, 16'h0000, 10'h208);
    add_vec("sta",        16'h0020, 16'h0055, 16'h9500, NOP, NOP, NOP, 6, 16'h0020, 16'h0000, 10'h206);
    add_vec("std",        16'h0009, 16'h0044, 16'h9602, NOP, NOP, NOP, 6, 16'h0009, 16'h0000, 10'h206);

    foreach (vecs[i]) begin
      clear_mem();
      for (int k = 0; k < 6; k++) mem[256 + k] = vecs[i].prog[k];
      do_reset();
      step(vecs[i].cycles);
      check({vecs[i].name, " top"},   32'(dut.stack[0]), 32'(vecs[i].top));
      check({vecs[i].name, " s1"},    32'(dut.stack[1]), 32'(vecs[i].s1));
      check({vecs[i].name, " pc"},    32'(dut.pc),       32'(vecs[i].pc));
      check({vecs[i].name, " phase"}, 32'(dut.phase),    32'd0);
    end

    // Word store: one write cycle, in the execute phase of the fourth instruction.
    clear_mem();
    mem[256] = 16'h0003;
    mem[257] = 16'h0004;
    mem[258] = 16'hB002;
    mem[259] = 16'h9602;
    do_reset();
    check("fetch addr after reset", 32'(mem_addr), 32'h200);
    step(6);
    check("alu done pc", 32'(dut.pc), 32'h206);
    check("alu done top", 32'(dut.stack[0]), 32'h0007);
    check("no early write", 32'(wr_cnt), 32'd0);
    step(1);
    check("store mem_wr", 32'(mem_wr), 32'd1);
    check("store addr", 32'(mem_addr), 32'h002);
    check("store data", 32'(wr_data), 32'h0007);
    step(1);
    check("store done pc", 32'(dut.pc), 32'h208);
    check("store done top", 32'(dut.stack[0]), 32'h0000);
    step(4);
    check("store write count", 32'(wr_cnt), 32'd1);
    check("store write cycle", 32'(w_cyc), 32'd7);

    // Reset asserted in the middle of the store cycle must kill mem_wr at once.
    do_reset();
    step(7);
    rst = 1'b1;
    #1;
    check("mem_wr low in reset", 32'(mem_wr), 32'd0);

    // Byte store writes a zero-extended low byte to the raw byte address.
    clear_mem();
    mem[256] = 16'h0011;
    mem[257] = 16'h1234;
    mem[258] = 16'h9C00;
    do_reset();
    step(6);
    check("st1 write count", 32'(wr_cnt), 32'd1);
    check("st1 write cycle", 32'(w_cyc), 32'd5);
    check("st1 addr", 32'(w_addr), 32'h011);
    check("st1 data", 32'(w_data), 32'h0034);

    // Load timing: address out in execute, writeback one cycle later.
    clear_mem();
    mem[256] = 16'h9102;
    do_reset();
    step(1);
    check("ldd addr", 32'(mem_addr), 32'h002);
    check("ldd mem_wr", 32'(mem_wr), 32'd0);
    step(1);
    check("ldd phase2", 32'(dut.phase), 32'd2);
    check("ldd phase2 pc", 32'(dut.pc), 32'h200);
    check("ldd phase2 top", 32'(dut.stack[0]), 32'h0000);
    step(1);
    check("ldd wb top", 32'(dut.stack[0]), 32'h0041);
    check("ldd wb pc", 32'(dut.pc), 32'h202);

    // jnz loop: each iteration pushes 1 and the branch consumes it.
    clear_mem();
    mem[256] = 16'h0009;
    mem[257] = 16'h0001;
    mem[258] = 16'hA2FE;
    do_reset();
    step(2);
    check("loop pc1", 32'(dut.pc), 32'h202);
    step(2);
    check("loop pc2", 32'(dut.pc), 32'h204);
    check("loop top before jnz", 32'(dut.stack[0]), 32'h0001);
    step(2);
    check("loop pc3", 32'(dut.pc), 32'h202);
    check("loop top after jnz", 32'(dut.stack[0]), 32'h0009);
    check("loop s1 after jnz", 32'(dut.stack[1]), 32'h0000);
    step(2);
    check("loop pc4", 32'(dut.pc), 32'h204);
    step(2);
    check("loop pc5", 32'(dut.pc), 32'h202);
    check("loop top again", 32'(dut.stack[0]), 32'h0009);

    // Branch target wraps modulo 1024.
    clear_mem();
    mem[256]   = 16'hA07F;
    mem[9'h180] = 16'hA07F;
    mem[0]     = 16'h0077;
    do_reset();
    step(2);
    check("jmp far pc", 32'(dut.pc), 32'h300);
    step(2);
    check("jmp wrap pc", 32'(dut.pc), 32'h000);
    step(2);
    check("wrap exec top", 32'(dut.stack[0]), 32'h0077);
    check("wrap exec pc", 32'(dut.pc), 32'h002);

    // Stack depth: 17 pushes lose the first value, pops refill with zero.
    clear_mem();
    for (int k = 0; k < 17; k++) mem[256 + k] = 16'(k + 1);
    for (int k = 0; k < 16; k++) mem[273 + k] = 16'h8100;
    do_reset();
    step(34);
    check("depth top", 32'(dut.stack[0]), 32'h0011);
    check("depth bottom", 32'(dut.stack[15]), 32'h0002);
    step(2);
    check("pop1 top", 32'(dut.stack[0]), 32'h0010);
    check("pop1 bottom", 32'(dut.stack[15]), 32'h0000);
    step(28);
    check("pop15 top", 32'(dut.stack[0]), 32'h0002);
    step(2);
    check("pop16 top", 32'(dut.stack[0]), 32'h0000);
    check("pop16 s1", 32'(dut.stack[1]), 32'h0000);

    // Reset from a fully populated stack.
    do_reset();
    step(34);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset pc", 32'(dut.pc), 32'h200);
    check("reset phase", 32'(dut.phase), 32'd0);
    check("reset insn", 32'(dut.insn), 32'h0000);
    check("reset mem_wr", 32'(mem_wr), 32'd0);
    for (int k = 0; k < 16; k++) check($sformatf("reset stack%0d", k), 32'(dut.stack[k]), 32'h0000);
    rst = 1'b0;
    check("first fetch addr", 32'(mem_addr), 32'h200);
    step(1);
    check("first exec phase", 32'(dut.phase), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_cpu.md
# stack_cpu

16-bit stack-machine processor core with a 16-entry on-chip operand stack and one shared synchronous memory port. It fetches 16-bit instructions and executes them in 2 or 3 clock phases. It sits between the system clock/reset and a word-organised RAM with a 1-cycle read latency. Byte address 0x002 of that RAM space is the UART data port; the CPU treats it as ordinary memory.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_addr  out  10  byte address; memory uses mem_addr>>1 as word index
- rd_data  in  16  read data, registered by memory on the clock edge after mem_addr is presented
- wr_data  out  16  store data, valid when mem_wr=1
- mem_wr  out  1  write strobe; memory writes wr_data on this clock edge
- Debug-visible internal registers (names fixed):
  - pc: 10-bit byte address
  - phase: 2-bit
  - insn: 16-bit
  - alu_out: 16-bit
  - stack[0:15]: 16-bit each; stack[0] is top of stack

## Operation
**Stack model**
- push: stack[i+1]←stack[i], stack[0]←value; stack[15] is lost.
- pop: stack[i]←stack[i+1], stack[15]←0.
- No overflow or underflow detection.

**Encoding (insn[15:8])**
- 0xxxxxxx push: push {1'b0, insn[14:0]}.
- 0x81 pop: pop.
- 0x82 dup: push stack[0].
- 0x90 ld: A=stack[0]; replace top with mem[A].
- 0x91 ldd: push mem[insn[7:0]] (direct byte address).
- 0x94 st: mem[stack[1]]←stack[0]; pop both.
- 0x95 sta: mem[stack[1]]←stack[0]; pop data only, keep address.
- 0x96 std: mem[insn[7:0]]←stack[0]; pop.
- 0x98–0x9E (.1 variants of the above): byte width.
  - Load: push zero-extended byte, rd_data[15:8] if addr[0]=1, else rd_data[7:0].
  - Store: wr_data={8'h00, data[7:0]}, full-word write.
- 0xA0 jmp: pc←pc+2+(sext(insn[7:0])<<1).
- 0xA1 jz: pop c; branch as jmp if c==0.
- 0xA2 jnz: pop c; branch if c!=0.
- 0xB0 ALU, function in insn[7:0]; B=stack[0], A=stack[1]; pop two, push A op B:
  - 02 add
  - 03 sub (A−B)
  - 04 mul (low 16 bits)
  - 05 join {A[7:0],B[7:0]}
  - 08 lt (signed, result 1/0)
  - 09 eq
  - 0a neq
  - 10 and
  - 11 xor
  - 12 or
  - 14 shr (logical, amount B[3:0])
  - 15 shl
  - 16 sar (arithmetic)
  - 13 not: unary, stack[0]←~stack[0].
- Undefined opcodes and undefined ALU functions: no-op, pc advances by 2.
- alu_out always shows the combinational ALU result for the current insn.

## Timing
- Reset (rst=1 at a clock edge), regardless of phase:
  - pc←0x200, phase←0, insn←0, all stack entries←0.
  - mem_wr=0 while rst is high.
- Phase 0 (fetch): mem_addr=pc, mem_wr=0. On the edge, memory latches the instruction.
- Phase 1 (execute):
  - Decode uses rd_data directly; insn←rd_data on the edge.
  - Non-memory instructions: stack/pc update on this edge, pc←pc+2 unless branching, next phase 0. Total 2 cycles.
  - Stores: mem_addr=target, wr_data=data, mem_wr=1 for exactly this cycle; stack updates on the same edge; next phase 0. Total 2 cycles.
  - Loads: mem_addr=target; next phase 2.
- Phase 2 (load writeback): push or replace top with rd_data (byte-selected for .1); pc←pc+2; next phase 0. Total 3 cycles.
- mem_wr is asserted only in phase 1 of a store instruction.
- Branch-taken target wraps modulo 1024. pc bit 0 is always 0.
- Stack shift and result write happen on the same edge; there are no intermediate stack states.

## Test plan
- Reset behaviour: hold rst 2 cycles → pc=0x200, phase=0, stack all 0, mem_wr=0. First fetch after release has mem_addr=0x200.
- Arithmetic and store: program 0003, 0004, B002, 9602 → one write cycle with mem_addr=0x002, wr_data=0x0007. The ALU op takes 2 cycles and the store completes 2 cycles later.
- Signed compare and shift: push 0x7FFF, push 1, add, push 1, sar → top=0xC000. Push 0x7FFF, push 0x8000 (via join/shl), lt → 0.
- Branch: push 0, A1 02 skips 2 words. push 1, A2 FE loops back to the jnz's predecessor. Check pc sequence and that one stack entry is consumed per conditional branch.
- Loads: 9102 with rd_data at address 2 = 0x0041 → top=0x0041 after 3 cycles. ld.1 at odd address selects rd_data[15:8].
- Stack depth: push 17 values, pop 16 → the first value is lost and stack[15] refills with 0.
